camera_luma_mac: RTL and testbench

Sequential RGB-to-luma converter in the uDMA camera datapath. It accepts one RGB888 pixel per handshake and time-multiplexes a single external combinational 8x8 unsigned multiplier over three cycles, driving its operands and consuming its 16-bit product. It accumulates and rounds the weighted sum, saturates it, and presents an 8-bit luma sample on a valid/ready stream to the downstream packer.

---
 rtl/camera_luma_mac_if.sv | 22 ++
 rtl/camera_luma_mac.sv | 120 ++++++++++++
 tb/tb_camera_luma_mac.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_luma_mac_if.sv
// Pixel-in / luma-out stream bundle for camera_luma_mac.
// The slave side is the converter; the master side is the camera front end plus the packer.
interface camera_luma_mac_if;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix_r;
   logic [7:0] pix_g;
   logic [7:0] pix_b;
   logic       luma_valid;
   logic       luma_ready;
   logic [7:0] luma_data;

   modport master (
      output pix_valid, pix_r, pix_g, pix_b, luma_ready,
      input  pix_ready, luma_valid, luma_data
   );

   modport slave (
      input  pix_valid, pix_r, pix_g, pix_b, luma_ready,
      output pix_ready, luma_valid, luma_data
   );
endinterface

// File: rtl/camera_luma_mac.sv
// RGB888 to 8-bit luma converter that time-shares one external 8x8 multiplier
// over three cycles per pixel and emits a saturated, optionally rounded result.
module camera_luma_mac #(
   parameter bit ROUND = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     cfg_en_i,
   input  logic [7:0]               cfg_coef_r_i,
   input  logic [7:0]               cfg_coef_g_i,
   input  logic [7:0]               cfg_coef_b_i,
   camera_luma_mac_if.slave         stream_io,
   output logic [7:0]               mult_a_o,
   output logic [7:0]               mult_b_o,
   input  logic [15:0]              mult_y_i,
   output logic                     busy_o
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] MUL_R = 3'd1;
   localparam logic [2:0] MUL_G = 3'd2;
   localparam logic [2:0] MUL_B = 3'd3;
   localparam logic [2:0] OUT   = 3'd4;

   localparam logic [17:0] ROUND_BIAS = ROUND ? 18'd128 : 18'd0;

   logic [2:0]  state_q, state_d;
   logic [17:0] acc_q, acc_d;
   logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic [7:0]  coefR_q, coefR_d, coefG_q, coefG_d, coefB_q, coefB_d;
   logic [7:0]  lumaData_q, lumaData_d;
   logic        pixReady;
   logic        pixAccept;
   logic [17:0] sum;

   assign pixReady  = cfg_en_i && ((state_q == IDLE) ||
                                   ((state_q == OUT) && stream_io.luma_ready));
   assign pixAccept = stream_io.pix_valid && pixReady;
   assign sum       = acc_q + {2'b00, mult_y_i};

   assign stream_io.pix_ready  = pixReady;
   assign stream_io.luma_valid = (state_q == OUT);
   assign stream_io.luma_data  = lumaData_q;
   assign busy_o               = (state_q != IDLE);

   always_comb begin
      mult_a_o = 8'd0;
      mult_b_o = 8'd0;
      case (state_q)
         MUL_R: begin mult_a_o = r_q; mult_b_o = coefR_q; end
         MUL_G: begin mult_a_o = g_q; mult_b_o = coefG_q; end
         MUL_B: begin mult_a_o = b_q; mult_b_o = coefB_q; end
         default: ;
      endcase
   end

   // A new pixel may be accepted in the same cycle the previous result hands off,
   // so the latch update sits outside the state case.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      r_d        = r_q;
      g_d        = g_q;
      b_d        = b_q;
      coefR_d    = coefR_q;
      coefG_d    = coefG_q;
      coefB_d    = coefB_q;
      lumaData_d = lumaData_q;
      case (state_q)
         IDLE:  if (pixAccept) state_d = MUL_R;
         MUL_R: begin
            acc_d   = {2'b00, mult_y_i} + ROUND_BIAS;
            state_d = MUL_G;
         end
         MUL_G: begin
            acc_d   = sum;
            state_d = MUL_B;
         end
         MUL_B: begin
            lumaData_d = (sum[17:8] > 10'd255) ? 8'hFF : sum[15:8];
            state_d    = OUT;
         end
         OUT:   if (stream_io.luma_ready) state_d = pixAccept ? MUL_R : IDLE;
         default: state_d = IDLE;
      endcase
      if (pixAccept) begin
         r_d     = stream_io.pix_r;
         g_d     = stream_io.pix_g;
         b_d     = stream_io.pix_b;
         coefR_d = cfg_coef_r_i;
         coefG_d = cfg_coef_g_i;
         coefB_d = cfg_coef_b_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         acc_q      <= 18'd0;
         r_q        <= 8'd0;
         g_q        <= 8'd0;
         b_q        <= 8'd0;
         coefR_q    <= 8'd0;
         coefG_q    <= 8'd0;
         coefB_q    <= 8'd0;
         lumaData_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
         coefR_q    <= coefR_d;
         coefG_q    <= coefG_d;
         coefB_q    <= coefB_d;
         lumaData_q <= lumaData_d;
      end
   end

endmodule

// File: tb/tb_camera_luma_mac.sv
// Self-checking bench for camera_luma_mac: a rounding and a truncating instance
// share one stimulus and are compared every cycle against a behavioural model.
module tb_camera_luma_mac;

   logic       clk;
   logic       rstn;
   logic       cfgEn;
   logic [7:0] coefR, coefG, coefB;
   logic       pixValid;
   logic [7:0] pixR, pixG, pixB;
   logic       lumaReady;

   logic [7:0]  multA1, multB1, multA0, multB0;
   logic [15:0] multY1, multY0;
   logic        busy1, busy0;

   int nChecks = 0;
   int nFails  = 0;

   camera_luma_mac_if ifR ();
   camera_luma_mac_if ifT ();

   assign ifR.pix_valid  = pixValid;
   assign ifR.pix_r      = pixR;
   assign ifR.pix_g      = pixG;
   assign ifR.pix_b      = pixB;
   assign ifR.luma_ready = lumaReady;
   assign ifT.pix_valid  = pixValid;
   assign ifT.pix_r      = pixR;
   assign ifT.pix_g      = pixG;
   assign ifT.pix_b      = pixB;
   assign ifT.luma_ready = lumaReady;

   // External combinational multipliers, one per instance.
   assign multY1 = {8'd0, multA1} * {8'd0, multB1};
   assign multY0 = {8'd0, multA0} * {8'd0, multB0};

   camera_luma_mac #(.ROUND(1'b1)) dut (
      .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfgEn),
      .cfg_coef_r_i(coefR), .cfg_coef_g_i(coefG), .cfg_coef_b_i(coefB),
      .stream_io(ifR.slave),
      .mult_a_o(multA1), .mult_b_o(multB1), .mult_y_i(multY1), .busy_o(busy1)
   );

   camera_luma_mac #(.ROUND(1'b0)) dutTrunc (
      .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfgEn),
      .cfg_coef_r_i(coefR), .cfg_coef_g_i(coefG), .cfg_coef_b_i(coefB),
      .stream_io(ifT.slave),
      .mult_a_o(multA0), .mult_b_o(multB0), .mult_y_i(multY0), .busy_o(busy0)
   );

   // 10 ns clock; stimulus changes 2 ns after each rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int lumaOf(input int r, input int g, input int b,
                                 input int cr, input int cg, input int cb,
                                 input bit rnd);
      int s;
      s = (r * cr + g * cg + b * cb + (rnd ? 128 : 0)) / 256;
      return (s > 255) ? 255 : s;
   endfunction

   // Behavioural model: a pixel is in flight from its accept edge; it shows
   // operands for three cycles, then holds its result until downstream ready.
   bit inFlight = 1'b0;
   int age      = 0;
   int opA[3];
   int opB[3];
   int exp1     = 0;
   int exp0     = 0;
   int cycleNo  = 0;
   int hsCycle[$];
   bit checkEn  = 1'b0;

   always @(posedge clk) begin : modelStep
      bit rdy;
      bit acc;
      bit hs;
      cycleNo++;
      if (!rstn) begin
         inFlight = 1'b0;
         age      = 0;
      end else begin
         rdy = cfgEn && (!inFlight || (age >= 4 && lumaReady));
         acc = pixValid && rdy;
         hs  = inFlight && (age >= 4) && lumaReady;
         if (hs) begin
            inFlight = 1'b0;
            hsCycle.push_back(cycleNo);
         end else if (inFlight) begin
            age++;
         end
         if (acc) begin
            inFlight = 1'b1;
            age      = 1;
            opA[0] = pixR;  opA[1] = pixG;  opA[2] = pixB;
            opB[0] = coefR; opB[1] = coefG; opB[2] = coefB;
            exp1 = lumaOf(pixR, pixG, pixB, coefR, coefG, coefB, 1'b1);
            exp0 = lumaOf(pixR, pixG, pixB, coefR, coefG, coefB, 1'b0);
         end
      end
   end

   always @(negedge clk) begin : compare
      int  expA;
      int  expB;
      bit  expReady;
      bit  expValid;
      if (checkEn) begin
         expReady = cfgEn && (!inFlight || (age >= 4 && lumaReady));
         expValid = inFlight && (age >= 4);
         expA = 0;
         expB = 0;
         if (inFlight && age >= 1 && age <= 3) begin
            expA = opA[age - 1];
            expB = opB[age - 1];
         end
         checkOutput("pix_ready",  ifR.pix_ready,  expReady);
         checkOutput("luma_valid", ifR.luma_valid, expValid);
         checkOutput("busy",       busy1,          inFlight);
         checkOutput("mult_a",     multA1,         expA);
         checkOutput("mult_b",     multB1,         expB);
         checkOutput("t_pix_ready",  ifT.pix_ready,  expReady);
         checkOutput("t_luma_valid", ifT.luma_valid, expValid);
         checkOutput("t_busy",       busy0,          inFlight);
         checkOutput("t_mult_a",     multA0,         expA);
         checkOutput("t_mult_b",     multB0,         expB);
         if (expValid) begin
            checkOutput("luma_data",   ifR.luma_data, exp1);
            checkOutput("t_luma_data", ifT.luma_data, exp0);
         end
      end
   end

   // Present a pixel and hold it until accepted; returns 2 ns into the first MUL cycle.
   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      pixR     = r;
      pixG     = g;
      pixB     = b;
      pixValid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ifR.pix_ready === 1'b1) begin
            @(posedge clk);
            #2;
            pixValid = 1'b0;
            return;
         end
      end
      checkOutput("accept_timeout", ifR.pix_ready, 1);
      pixValid = 1'b0;
   endtask

   task automatic waitOutput(input string name, input int e1, input int e0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ifR.luma_valid === 1'b1) begin
            checkOutput(name, ifR.luma_data, e1);
            checkOutput({name, "_trunc"}, ifT.luma_data, e0);
            @(posedge clk);
            #2;
            return;
         end
      end
      checkOutput({name, "_timeout"}, ifR.luma_valid, 1);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #2;
   endtask

   logic [7:0] sr[8], sg[8], sb[8];

   initial begin
      rstn      = 1'b0;
      cfgEn     = 1'b1;
      coefR     = 8'd77;
      coefG     = 8'd150;
      coefB     = 8'd29;
      pixValid  = 1'b0;
      pixR      = 8'd0;
      pixG      = 8'd0;
      pixB      = 8'd0;
      lumaReady = 1'b1;

      // Pin the model against hand-computed values.
      checkOutput("model_white",   lumaOf(255, 255, 255, 77, 150, 29, 1'b1), 255);
      checkOutput("model_82",      lumaOf(100, 50, 200, 77, 150, 29, 1'b1), 82);
      checkOutput("model_black",   lumaOf(0, 0, 0, 77, 150, 29, 1'b1), 0);
      checkOutput("model_sat",     lumaOf(255, 255, 255, 255, 255, 255, 1'b1), 255);
      checkOutput("model_trunc0",  lumaOf(128, 127, 0, 1, 1, 1, 1'b0), 0);
      checkOutput("model_trunc1",  lumaOf(128, 128, 0, 1, 1, 1, 1'b0), 1);

      stepCycle();
      checkEn = 1'b1;
      stepCycle();
      @(negedge clk);
      checkOutput("rst_valid", ifR.luma_valid, 0);
      checkOutput("rst_data",  ifR.luma_data, 0);
      checkOutput("rst_busy",  busy1, 0);
      checkOutput("rst_ready", ifR.pix_ready, 1);
      @(posedge clk);
      #2;
      rstn = 1'b1;
      stepCycle();

      // White pixel: latency and operand sequence.
      applyStimulus(8'd255, 8'd255, 8'd255);
      checkOutput("lat_c1_valid", ifR.luma_valid, 0);
      stepCycle();
      stepCycle();
      checkOutput("lat_c3_valid", ifR.luma_valid, 0);
      stepCycle();
      checkOutput("lat_c4_valid", ifR.luma_valid, 1);
      checkOutput("white", ifR.luma_data, 255);
      stepCycle();

      applyStimulus(8'd100, 8'd50, 8'd200);
      checkOutput("op_r_a", multA1, 100);
      checkOutput("op_r_b", multB1, 77);
      stepCycle();
      checkOutput("op_g_a", multA1, 50);
      checkOutput("op_g_b", multB1, 150);
      stepCycle();
      checkOutput("op_b_a", multA1, 200);
      checkOutput("op_b_b", multB1, 29);
      stepCycle();
      checkOutput("op_out_a", multA1, 0);
      checkOutput("op_out_b", multB1, 0);
      checkOutput("px_82", ifR.luma_data, 82);
      checkOutput("px_82_trunc", ifT.luma_data, 82);
      stepCycle();

      applyStimulus(8'd0, 8'd0, 8'd0);
      waitOutput("black", 0, 0);

      coefR = 8'd255; coefG = 8'd255; coefB = 8'd255;
      applyStimulus(8'd255, 8'd255, 8'd255);
      waitOutput("saturate", 255, 255);

      coefR = 8'd1; coefG = 8'd1; coefB = 8'd1;
      applyStimulus(8'd128, 8'd127, 8'd0);
      waitOutput("round_127", 1, 0);
      applyStimulus(8'd128, 8'd128, 8'd0);
      waitOutput("round_128", 1, 1);

      // Backpressure then streaming of eight queued pixels.
      coefR = 8'd77; coefG = 8'd150; coefB = 8'd29;
      for (int k = 0; k < 8; k++) begin
         sr[k] = 8'($urandom); sg[k] = 8'($urandom); sb[k] = 8'($urandom);
      end
      lumaReady = 1'b0;
      applyStimulus(8'd10, 8'd20, 8'd30);
      pixR = sr[0]; pixG = sg[0]; pixB = sb[0];
      pixValid = 1'b1;
      stepCycle();
      stepCycle();
      stepCycle();
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_data",  ifR.luma_data, 18);
         checkOutput("bp_valid", ifR.luma_valid, 1);
         checkOutput("bp_ready", ifR.pix_ready, 0);
         stepCycle();
      end
      lumaReady = 1'b1;
      for (int k = 0; k < 8; k++) applyStimulus(sr[k], sg[k], sb[k]);
      waitOutput("stream_last",
                 lumaOf(sr[7], sg[7], sb[7], 77, 150, 29, 1'b1),
                 lumaOf(sr[7], sg[7], sb[7], 77, 150, 29, 1'b0));
      for (int k = hsCycle.size() - 8; k < hsCycle.size(); k++)
         checkOutput("stream_gap", hsCycle[k] - hsCycle[k - 1], 4);

      // Coefficient change while in flight.
      applyStimulus(8'd100, 8'd50, 8'd200);
      coefG = 8'd0;
      waitOutput("coef_hold", 82, 82);
      coefG = 8'd150;

      // Enable dropped mid-pixel.
      applyStimulus(8'd60, 8'd70, 8'd80);
      stepCycle();
      cfgEn = 1'b0;
      pixValid = 1'b1;
      waitOutput("en_drop", 68, 68);
      for (int i = 0; i < 4; i++) begin
         checkOutput("en_drop_ready", ifR.pix_ready, 0);
         checkOutput("en_drop_busy",  busy1, 0);
         stepCycle();
      end
      pixValid = 1'b0;
      cfgEn = 1'b1;

      // Reset in MUL_G discards the pixel.
      applyStimulus(8'd100, 8'd50, 8'd200);
      stepCycle();
      rstn = 1'b0;
      stepCycle();
      checkOutput("rst_mid_valid", ifR.luma_valid, 0);
      checkOutput("rst_mid_busy",  busy1, 0);
      checkOutput("rst_mid_a",     multA1, 0);
      checkOutput("rst_mid_b",     multB1, 0);
      checkOutput("rst_mid_data",  ifR.luma_data, 0);
      rstn = 1'b1;
      applyStimulus(8'd255, 8'd255, 8'd255);
      waitOutput("after_reset", 255, 255);

      // Randomised traffic against the model.
      for (int i = 0; i < 800; i++) begin
         pixValid  = ($urandom_range(3) != 0);
         pixR      = 8'($urandom);
         pixG      = 8'($urandom);
         pixB      = 8'($urandom);
         if ($urandom_range(7) == 0) begin
            coefR = 8'($urandom); coefG = 8'($urandom); coefB = 8'($urandom);
         end
         cfgEn     = ($urandom_range(15) != 0);
         lumaReady = ($urandom_range(2) != 0);
         rstn      = ($urandom_range(63) != 0);
         stepCycle();
      end
      rstn = 1'b1;
      pixValid = 1'b0;
      stepCycle();
      stepCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
